dda_stepper: RTL and testbench

DDA_STEPPER -- requirements
Module: dda_stepper

---
 rtl/dda_pkg.sv | 30 +++
 rtl/dda_stepper.sv | 185 ++++++++++++++++++
 tb/tb_dda_stepper.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dda_pkg.sv
// dda_pkg: shared state encoding, Q8.8 constants and wall codes for dda_stepper.
// Revision 1.0
`default_nettype none

package dda_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STEP  = 3'd2,
    ST_FETCH = 3'd3,
    ST_WAIT  = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [15:0] ONE       = 16'h0100;
  localparam logic [15:0] DIST_MAX  = 16'hFFFF;
  localparam logic [3:0]  WALL_NONE = 4'h0;
  localparam logic [3:0]  WALL_OOB  = 4'hF;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? DIST_MAX : sum[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dda_stepper.sv
// dda_stepper: grid DDA ray walker; steps one cell per map lookup until a wall,
// the map edge or the step limit is reached. Revision 1.0
`default_nettype none

module dda_stepper
  import dda_pkg::*;
#(
  parameter int MAP_SIZE    = 24,
  parameter int MAX_STEPS   = 64,
  parameter int MAP_LATENCY = 2
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        valid_ray_in,
  input  logic        stepX,
  input  logic        stepY,
  input  logic [15:0] posX,
  input  logic [15:0] posY,
  input  logic [15:0] sideDistX,
  input  logic [15:0] sideDistY,
  input  logic [15:0] deltaDistX,
  input  logic [15:0] deltaDistY,
  input  logic [8:0]  hcount_in,
  output logic        dda_data_ready_out,
  output logic [9:0]  map_addr_out,
  input  logic [3:0]  map_data_in,
  input  logic        ready_in,
  output logic        valid_out,
  output logic [8:0]  hcount_out,
  output logic [3:0]  wall_type_out,
  output logic        side_out,
  output logic [15:0] perp_dist_out,
  output logic [6:0]  map_x_out,
  output logic [6:0]  map_y_out
);

  localparam int CNT_W     = $clog2(MAX_STEPS + 1);
  localparam int WAIT_W    = $clog2(MAP_LATENCY + 1);
  localparam int WAIT_LAST = (MAP_LATENCY > 1) ? MAP_LATENCY - 2 : 0;
  localparam logic signed [7:0] SIZE_S = 8'(MAP_SIZE);
  localparam logic [9:0]        SIZE_A = 10'(MAP_SIZE);

  state_t state, state_nxt;

  logic               dir_x, dir_y;
  logic [7:0]         cell_x0, cell_y0;
  logic [15:0]        side_x, side_y, delta_x, delta_y;
  logic [8:0]         hcount_q;
  logic signed [7:0]  map_x, map_y;
  logic               side;
  logic [CNT_W-1:0]   step_cnt;
  logic [WAIT_W-1:0]  wait_cnt;

  logic               accept, take_x, nxt_oob, cur_oob, wall_hit, timeout, finish;
  logic signed [7:0]  nxt_x, nxt_y;
  logic [9:0]         nxt_addr;
  logic               unused_frac;

  // Only the integer part of the position seeds the walk.
  assign unused_frac = ^((posX | posY) & (ONE - 16'h0001));

  function automatic logic is_oob(input logic signed [7:0] x, input logic signed [7:0] y);
    return (x < 8'sd0) || (x >= SIZE_S) || (y < 8'sd0) || (y >= SIZE_S);
  endfunction

  assign dda_data_ready_out = (state == ST_IDLE);
  assign accept   = valid_ray_in && dda_data_ready_out;

  // Ties go to the Y axis.
  assign take_x   = side_x < side_y;
  assign nxt_x    = take_x ? map_x + (dir_x ? 8'sd1 : -8'sd1) : map_x;
  assign nxt_y    = take_x ? map_y : map_y + (dir_y ? 8'sd1 : -8'sd1);
  assign nxt_oob  = is_oob(nxt_x, nxt_y);
  assign nxt_addr = {3'b000, nxt_y[6:0]} * SIZE_A + {3'b000, nxt_x[6:0]};

  assign cur_oob  = is_oob(map_x, map_y);
  assign wall_hit = (map_data_in != WALL_NONE);
  assign timeout  = (step_cnt == CNT_W'(MAX_STEPS));
  assign finish   = cur_oob || wall_hit || timeout;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_STEP;
      ST_STEP:  state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = (MAP_LATENCY > 1) ? ST_WAIT : ST_CHECK;
      ST_WAIT:  if (wait_cnt == WAIT_W'(WAIT_LAST)) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = finish ? ST_DONE : ST_STEP;
      ST_DONE:  if (ready_in) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dir_x         <= 1'b0;
      dir_y         <= 1'b0;
      cell_x0       <= '0;
      cell_y0       <= '0;
      side_x        <= '0;
      side_y        <= '0;
      delta_x       <= '0;
      delta_y       <= '0;
      hcount_q      <= '0;
      map_x         <= '0;
      map_y         <= '0;
      side          <= 1'b0;
      step_cnt      <= '0;
      wait_cnt      <= '0;
      map_addr_out  <= '0;
      valid_out     <= 1'b0;
      hcount_out    <= '0;
      wall_type_out <= '0;
      side_out      <= 1'b0;
      perp_dist_out <= '0;
      map_x_out     <= '0;
      map_y_out     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Capture on the handshake: upstream may change its bus afterwards.
          if (accept) begin
            dir_x    <= stepX;
            dir_y    <= stepY;
            cell_x0  <= posX[15:8];
            cell_y0  <= posY[15:8];
            side_x   <= sideDistX;
            side_y   <= sideDistY;
            delta_x  <= deltaDistX;
            delta_y  <= deltaDistY;
            hcount_q <= hcount_in;
          end
        end
        ST_LOAD: begin
          map_x    <= signed'(cell_x0);
          map_y    <= signed'(cell_y0);
          step_cnt <= '0;
        end
        ST_STEP: begin
          if (take_x) begin
            side_x <= sat_add(side_x, delta_x);
            side   <= 1'b0;
          end else begin
            side_y <= sat_add(side_y, delta_y);
            side   <= 1'b1;
          end
          map_x        <= nxt_x;
          map_y        <= nxt_y;
          map_addr_out <= nxt_oob ? 10'd0 : nxt_addr;
        end
        ST_FETCH: wait_cnt <= '0;
        ST_WAIT:  wait_cnt <= wait_cnt + WAIT_W'(1);
        ST_CHECK: begin
          if (finish) begin
            valid_out  <= 1'b1;
            hcount_out <= hcount_q;
            side_out   <= side;
            map_x_out  <= map_x[6:0];
            map_y_out  <= map_y[6:0];
            if (cur_oob || wall_hit) begin
              wall_type_out <= cur_oob ? WALL_OOB : map_data_in;
              perp_dist_out <= side ? side_y - delta_y : side_x - delta_x;
            end else begin
              wall_type_out <= WALL_NONE;
              perp_dist_out <= DIST_MAX;
            end
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        ST_DONE: if (ready_in) valid_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dda_stepper.sv
// tb_dda_stepper: directed and random rays against an arithmetic DDA reference.
// Revision 1.0
`default_nettype none

module tb_dda_stepper;

  localparam int MS   = 24;
  localparam int MAXS = 4;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic        valid_ray_in;
  logic        stepX, stepY;
  logic [15:0] posX, posY, sideDistX, sideDistY, deltaDistX, deltaDistY;
  logic [8:0]  hcount_in;
  logic        dda_data_ready_out;
  logic [9:0]  map_addr_out;
  logic [3:0]  map_data_in;
  logic        ready_in;
  logic        valid_out;
  logic [8:0]  hcount_out;
  logic [3:0]  wall_type_out;
  logic        side_out;
  logic [15:0] perp_dist_out;
  logic [6:0]  map_x_out, map_y_out;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] mem  [0:1023];
  logic [3:0] pipe [LAT];

  typedef struct {
    int wall; int side; int perp; int mx; int my; int k;
  } res_t;

  dda_stepper #(.MAP_SIZE(MS), .MAX_STEPS(MAXS), .MAP_LATENCY(LAT)) dut (
    .pixel_clk_in      (clk),
    .rst_n_in          (rst_n_in),
    .valid_ray_in      (valid_ray_in),
    .stepX             (stepX),
    .stepY             (stepY),
    .posX              (posX),
    .posY              (posY),
    .sideDistX         (sideDistX),
    .sideDistY         (sideDistY),
    .deltaDistX        (deltaDistX),
    .deltaDistY        (deltaDistY),
    .hcount_in         (hcount_in),
    .dda_data_ready_out(dda_data_ready_out),
    .map_addr_out      (map_addr_out),
    .map_data_in       (map_data_in),
    .ready_in          (ready_in),
    .valid_out         (valid_out),
    .hcount_out        (hcount_out),
    .wall_type_out     (wall_type_out),
    .side_out          (side_out),
    .perp_dist_out     (perp_dist_out),
    .map_x_out         (map_x_out),
    .map_y_out         (map_y_out)
  );

  always #5 clk = ~clk;

  // External map memory with LAT cycles of read latency.
  assign map_data_in = pipe[LAT-1];
  always @(posedge clk) begin
    pipe[0] <= mem[map_addr_out];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
  endtask

  task automatic random_map();
    clear_map();
    for (int i = 0; i < MS * MS; i++)
      if ($urandom_range(0, 4) == 0) mem[i] = 4'($urandom_range(1, 14));
  endtask

  function automatic res_t model(input logic [15:0] px, input logic [15:0] py,
                                 input logic [15:0] sdx, input logic [15:0] sdy,
                                 input logic [15:0] ddx, input logic [15:0] ddy,
                                 input logic sx, input logic sy);
    res_t r;
    int mx, my, ax, ay, sd;
    mx = int'(px[15:8]);
    my = int'(py[15:8]);
    ax = int'(sdx);
    ay = int'(sdy);
    sd = 0;
    r = '{wall: 0, side: 0, perp: 0, mx: 0, my: 0, k: 0};
    for (int n = 0; n <= MAXS; n++) begin
      if (ax < ay) begin
        ax = (ax + int'(ddx) > 65535) ? 65535 : ax + int'(ddx);
        mx = mx + (sx ? 1 : -1);
        sd = 0;
      end else begin
        ay = (ay + int'(ddy) > 65535) ? 65535 : ay + int'(ddy);
        my = my + (sy ? 1 : -1);
        sd = 1;
      end
      r.k = n + 1; r.mx = mx; r.my = my; r.side = sd;
      r.perp = (sd == 1) ? ((ay - int'(ddy)) & 32'hFFFF) : ((ax - int'(ddx)) & 32'hFFFF);
      if (mx < 0 || mx >= MS || my < 0 || my >= MS) begin
        r.wall = 15;
        return r;
      end
      if (mem[my * MS + mx] != 4'h0) begin
        r.wall = int'(mem[my * MS + mx]);
        return r;
      end
      if (n == MAXS) begin
        r.wall = 0;
        r.perp = 65535;
        return r;
      end
    end
    return r;
  endfunction

  task automatic drive_ray(input logic [15:0] px, input logic [15:0] py,
                           input logic [15:0] sdx, input logic [15:0] sdy,
                           input logic [15:0] ddx, input logic [15:0] ddy,
                           input logic sx, input logic sy, input logic [8:0] hc);
    posX = px; posY = py; sideDistX = sdx; sideDistY = sdy;
    deltaDistX = ddx; deltaDistY = ddy; stepX = sx; stepY = sy; hcount_in = hc;
  endtask

  task automatic scramble();
    drive_ray(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 9'($urandom));
  endtask

  task automatic wait_accept();
    bit acc = 1'b0;
    int guard = 0;
    valid_ray_in = 1'b1;
    while (!acc && guard < 50) begin
      acc = (dda_data_ready_out === 1'b1);
      @(posedge clk); #1;
      guard++;
    end
    valid_ray_in = 1'b0;
    check("accept", 32'(acc), 32'd1);
  endtask

  task automatic run_ray(input logic [15:0] px, input logic [15:0] py,
                         input logic [15:0] sdx, input logic [15:0] sdy,
                         input logic [15:0] ddx, input logic [15:0] ddy,
                         input logic sx, input logic sy, input logic [8:0] hc,
                         input int hold, input bit exp_en,
                         input int e_wall, input int e_side, input int e_mx,
                         input int e_my, input int e_perp, input int e_k);
    res_t r;
    int edges;
    r = model(px, py, sdx, sdy, ddx, ddy, sx, sy);
    drive_ray(px, py, sdx, sdy, ddx, ddy, sx, sy, hc);
    wait_accept();
    scramble();
    edges = 1;
    while (valid_out !== 1'b1 && edges < 4000) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 32'(edges), 32'(2 + r.k * (2 + LAT)));
    check("wall",   32'(wall_type_out), 32'(r.wall));
    check("side",   32'(side_out),      32'(r.side));
    check("perp",   32'(perp_dist_out), 32'(r.perp));
    check("map_x",  32'(map_x_out),     32'(r.mx & 32'h7F));
    check("map_y",  32'(map_y_out),     32'(r.my & 32'h7F));
    check("hcount", 32'(hcount_out),    32'(hc));
    if (exp_en) begin
      check("dir_wall",  32'(wall_type_out), 32'(e_wall));
      check("dir_side",  32'(side_out),      32'(e_side));
      check("dir_map_x", 32'(map_x_out),     32'(e_mx));
      check("dir_map_y", 32'(map_y_out),     32'(e_my));
      check("dir_perp",  32'(perp_dist_out), 32'(e_perp));
      check("dir_lat",   32'(edges),         32'(2 + e_k * (2 + LAT)));
    end
    for (int i = 0; i < hold; i++) begin
      scramble();
      valid_ray_in = 1'b1;
      @(posedge clk); #1;
      check("bp_valid", 32'(valid_out), 32'd1);
      check("bp_ready", 32'(dda_data_ready_out), 32'd0);
      check("bp_hold", {3'b0, wall_type_out, side_out, map_x_out, map_y_out, hcount_out},
            {3'b0, 4'(r.wall), 1'(r.side), 7'(r.mx), 7'(r.my), hc});
      check("bp_perp", 32'(perp_dist_out), 32'(r.perp));
    end
    valid_ray_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    check("valid_drop", 32'(valid_out), 32'd0);
    check("back_idle",  32'(dda_data_ready_out), 32'd1);
  endtask

  initial begin
    bit saw;
    rst_n_in = 1'b0;
    valid_ray_in = 1'b0;
    ready_in = 1'b0;
    drive_ray('0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    clear_map();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(dda_data_ready_out), 32'd1);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_addr",  32'(map_addr_out), 32'd0);
    check("rst_wall",  32'(wall_type_out), 32'd0);
    check("rst_perp",  32'(perp_dist_out), 32'd0);
    rst_n_in = 1'b1;
    @(posedge clk); #1;

    // X-side hit at (5,2)
    clear_map(); mem[2 * MS + 5] = 4'h3;
    run_ray(16'h0280, 16'h0280, 16'h0080, 16'h7FFF, 16'h0100, 16'hFFFF, 1'b1, 1'b1, 9'd17,
            0, 1'b1, 3, 0, 5, 2, 16'h0280, 3);
    // Tie resolves toward Y
    clear_map(); mem[3 * MS + 2] = 4'h6;
    run_ray(16'h0280, 16'h0280, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b1, 9'd300,
            0, 1'b1, 6, 1, 2, 3, 16'h0100, 1);
    // Off the left edge
    clear_map();
    run_ray(16'h0080, 16'h0580, 16'h0080, 16'h0200, 16'h0100, 16'h0100, 1'b0, 1'b1, 9'd5,
            0, 1'b1, 15, 0, 7'h7F, 5, 16'h0080, 1);
    // Step limit on an empty map
    run_ray(16'h0C80, 16'h0C80, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b1, 1'b1, 9'd100,
            0, 1'b1, 0, 0, 17, 12, 16'hFFFF, 5);
    // Backpressure in DONE
    clear_map(); mem[2 * MS + 5] = 4'h3;
    run_ray(16'h0280, 16'h0280, 16'h0080, 16'h7FFF, 16'h0100, 16'hFFFF, 1'b1, 1'b1, 9'd42,
            10, 1'b1, 3, 0, 5, 2, 16'h0280, 3);

    // Reset while waiting on the map read
    clear_map();
    drive_ray(16'h0C80, 16'h0C80, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b1, 1'b1, 9'd9);
    wait_accept();
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_addr", 32'(map_addr_out), 32'(12 * MS + 13));
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_addr",  32'(map_addr_out), 32'd0);
    check("mid_rst_ready", 32'(dda_data_ready_out), 32'd1);
    check("mid_rst_res",   {9'b0, wall_type_out, side_out, map_x_out, map_y_out},
          32'd0);
    check("mid_rst_perp",  32'(perp_dist_out), 32'd0);
    @(posedge clk); #1;
    rst_n_in = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (valid_out !== 1'b0) saw = 1'b1;
    end
    check("no_result_after_rst", 32'(saw), 32'd0);
    clear_map(); mem[3 * MS + 2] = 4'h6;
    run_ray(16'h0280, 16'h0280, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b1, 9'd301,
            0, 1'b1, 6, 1, 2, 3, 16'h0100, 1);

    // Random rays against the reference walk
    for (int t = 0; t < 40; t++) begin
      logic [15:0] ddx, ddy;
      random_map();
      ddx = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                        : 16'($urandom_range(16'h0040, 16'h0400));
      ddy = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                        : 16'($urandom_range(16'h0040, 16'h0400));
      run_ray(16'($urandom_range(0, MS * 256 - 1)), 16'($urandom_range(0, MS * 256 - 1)),
              16'($urandom), 16'($urandom), ddx, ddy, 1'($urandom), 1'($urandom),
              9'($urandom), int'($urandom_range(0, 2)), 1'b0, 0, 0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
